// File: rtl/rpn_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rpn_ctrl
//
// Reverse-Polish evaluation controller. It is the only master of a LIFO
// `stack` block. Tokens arrive over a valid/ready handshake:
//   * an operand is pushed onto the stack;
//   * an operator pops the top (a), then the next entry (b), computes op(b,a)
//     modulo 2**B and pushes the result back.
// The controller keeps its own authoritative occupancy count (`depth`).
// Tokens that would overflow or underflow the stack are discarded, and a
// one-cycle `err` pulse is raised with a sticky `err_code`.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; also resets the stack instance
//   in_valid       token present
//   in_ready       controller can accept a token (high only in IDLE)
//   in_is_op       1: operator token, 0: operand token
//   in_data        operand value, or opcode in bits [1:0]
//   stk_push       stack push strobe
//   stk_pop        stack pop strobe
//   stk_push_data  value to push (always from a register)
//   stk_pop_data   combinational top of stack from the stack block
//   stk_empty      stack empty flag (not used for decisions)
//   stk_full       stack full flag (not used for decisions)
//   result         top of stack; meaningful while depth != 0
//   depth          number of stack entries, 0 .. 2**W
//   err            one-cycle error pulse
//   err_code       01 underflow, 10 overflow; holds between pulses
// ---------------------------------------------------------------------------
module rpn_ctrl #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_is_op,
  input  logic [B-1:0] in_data,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [B-1:0] stk_push_data,
  input  logic [B-1:0] stk_pop_data,
  input  logic         stk_empty,
  input  logic         stk_full,
  output logic [B-1:0] result,
  output logic [W:0]   depth,
  output logic         err,
  output logic [1:0]   err_code
);

  // Full-stack occupancy expressed in the width of the depth counter.
  localparam logic [W:0] CAP = (W+1)'(2**W);
  localparam logic [W:0] MIN_OPERANDS = (W+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_OP,
    S_POP_A,
    S_POP_B,
    S_EXEC,
    S_PUSH_RES,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [B-1:0] hold_q, hold_d;
  logic [B-1:0] a_q, a_d;
  logic [B-1:0] b_q, b_d;
  logic [B-1:0] res_q, res_d;
  logic [W:0]   depth_q, depth_d;
  logic [1:0]   err_code_q, err_code_d;
  logic [B-1:0] alu;

  // The stack's own flags mirror depth in normal operation; decisions are
  // taken from depth alone, so the flags are intentionally left unconsumed.
  logic unused_flags;
  assign unused_flags = stk_empty ^ stk_full;

  // --------------------------------------------------------------------------
  // Arithmetic on the latched operands. b is the older entry, a the top.
  // Everything wraps modulo 2**B; the multiply keeps only the low B bits.
  // --------------------------------------------------------------------------
  always_comb begin
    alu = '0;
    unique case (op_q)
      OP_ADD: alu = b_q + a_q;
      OP_SUB: alu = b_q - a_q;
      OP_MUL: alu = b_q * a_q;
      OP_AND: alu = b_q & a_q;
      default: alu = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    hold_d     = hold_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    depth_d    = depth_q;
    err_code_d = err_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          hold_d = in_data;
          if (!in_is_op) begin
            if (depth_q == CAP) begin
              state_d    = S_ERR;
              err_code_d = ERR_OVERFLOW;
            end else begin
              state_d = S_PUSH_OP;
            end
          end else begin
            if (depth_q < MIN_OPERANDS) begin
              state_d    = S_ERR;
              err_code_d = ERR_UNDERFLOW;
            end else begin
              op_d    = op_e'(in_data[1:0]);
              state_d = S_POP_A;
            end
          end
        end
      end

      S_PUSH_OP: begin
        depth_d = depth_q + 1'b1;
        state_d = S_IDLE;
      end

      // The stack presents its top combinationally, so each pop cycle
      // captures the value it is about to remove.
      S_POP_A: begin
        a_d     = stk_pop_data;
        depth_d = depth_q - 1'b1;
        state_d = S_POP_B;
      end

      S_POP_B: begin
        b_d     = stk_pop_data;
        depth_d = depth_q - 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        res_d   = alu;
        state_d = S_PUSH_RES;
      end

      S_PUSH_RES: begin
        depth_d = depth_q + 1'b1;
        state_d = S_IDLE;
      end

      // The offending token is simply dropped; err_code was already
      // latched on entry so it is valid for the whole pulse.
      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // Synchronous reset: only sampled on the rising edge, which keeps the
      // controller and the stack instance clearing on the same edge.
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      hold_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      depth_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hold_q     <= hold_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      depth_q    <= depth_d;
      err_code_q <= err_code_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only. Push and pop come from
  // disjoint states, so they can never be asserted together.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready      = (state_q == S_IDLE);
    stk_push      = (state_q == S_PUSH_OP) || (state_q == S_PUSH_RES);
    stk_pop       = (state_q == S_POP_A)   || (state_q == S_POP_B);
    stk_push_data = (state_q == S_PUSH_RES) ? res_q : hold_q;
    err           = (state_q == S_ERR);
    err_code      = err_code_q;
    depth         = depth_q;
    result        = stk_pop_data;
  end

endmodule

// File: doc/rpn_ctrl.md
# rpn_ctrl

Reverse-Polish evaluation controller that sits directly in front of the `stack` block and is its only master. It accepts a stream of tokens (operands or operators) over a valid/ready handshake. Operands are pushed onto the stack. Each operator pops two entries, computes a B-bit result and pushes the result back. It tracks stack depth itself, rejects overflow and underflow with an error pulse, and exposes the top of stack as the running result.

## Interface
Parameters:
- `B`, default 8: word width; must equal the `stack` instance's B.
- `W`, default 4: stack address bits; capacity is 2**W entries; must equal the `stack` instance's W.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset. Also drives the `stack` instance's reset.
- `in_valid`, input, 1: token present.
- `in_ready`, output, 1: controller can accept a token.
- `in_is_op`, input, 1: 1 means the token is an operator; 0 means it is an operand.
- `in_data`, input, B: operand value, or opcode in bits [1:0] (upper bits ignored).
- `stk_push`, output, 1: drives `stack.push`.
- `stk_pop`, output, 1: drives `stack.pop`.
- `stk_push_data`, output, B: drives `stack.push_data`.
- `stk_pop_data`, input, B: from `stack.pop_data`, the combinational top of stack.
- `stk_empty`, input, 1: from `stack.empty`.
- `stk_full`, input, 1: from `stack.full`.
- `result`, output, B: top of stack; valid when `depth != 0`.
- `depth`, output, W+1: number of entries, 0..2**W.
- `err`, output, 1: one-cycle error pulse.
- `err_code`, output, 2: 01 = underflow, 10 = overflow. Holds its last value between pulses.

## Operation
Opcodes:
- 00 ADD: b+a
- 01 SUB: b−a
- 10 MUL: low B bits of b*a
- 11 AND: b&a

Here a is the first value popped (the top) and b is the second. All arithmetic is modulo 2**B; no carry or overflow flag.

FSM states: IDLE, PUSH_OP, POP_A, POP_B, EXEC, PUSH_RES, ERR. The FSM resets to IDLE.
- IDLE:
  - `in_ready`=1; a token is accepted on `in_valid & in_ready`, and `in_data` is latched into `hold`.
  - Operand with `depth == 2**W`: go to ERR with code 10. Otherwise go to PUSH_OP.
  - Operator with `depth < 2`: go to ERR with code 01. Otherwise latch the opcode and go to POP_A.
- PUSH_OP: `stk_push`=1, `stk_push_data`=`hold`, depth+1, then IDLE.
- POP_A: latch `a`=`stk_pop_data`, `stk_pop`=1, depth−1, then POP_B.
- POP_B: latch `b`=`stk_pop_data`, `stk_pop`=1, depth−1, then EXEC.
- EXEC: register `res` = op(b,a), then PUSH_RES.
- PUSH_RES: `stk_push`=1, `stk_push_data`=`res`, depth+1, then IDLE.
- ERR: `err`=1, drive `err_code`, then IDLE. The token is discarded; depth and stack contents are unchanged.

Interface rules:
- `stk_push` and `stk_pop` are never asserted together.
- `stk_push` and `stk_pop` are decoded from the registered state only.
- `stk_push_data` comes only from registers (`hold`, `res`).
- `depth` is the authoritative occupancy count. In normal operation `stk_empty == (depth==0)` and `stk_full == (depth==2**W)`. The controller does not use `stk_full` or `stk_empty` for decisions; the bench checks this consistency.
- `result` = `stk_pop_data`. When `depth==0`, `result` is don't-care.

## Timing
Reset values of every output:
- `in_ready`=1, `stk_push`=0, `stk_pop`=0, `stk_push_data`=0, `err`=0, `err_code`=00, `depth`=0.
- Internal registers `hold`, `a`, `b` and `res` reset to 0.

Latency and throughput:
- Operand: accepted at edge N; `stk_push` is high in cycle N+1; the new top is visible on `result` after edge N+2. Throughput is 1 operand per 2 cycles.
- Operator: accepted at edge N; POP_A, POP_B, EXEC and PUSH_RES occupy cycles N+1..N+4; the result is on `result` after edge N+5. Throughput is 1 operator per 5 cycles.
- Error: `err` is high in cycle N+1 only; `in_ready` returns high in cycle N+2.

Handshake:
- `in_ready` is low in every state except IDLE.
- Tokens presented while `in_ready`=0 are not consumed; the source holds them.

Boundaries:
- A push at `depth==2**W−1` is legal and reaches `depth==2**W`.
- An operator at exactly `depth==2` is legal and leaves `depth==1`.
- `reset` asserted in any state forces IDLE and `depth`=0 on the next edge. Any in-flight operation is abandoned. The stack is cleared by the shared reset.

## Test plan
- Reset, then push 3, push 5, SUB -> `result`=8'hFE, `depth`=1, `err` never high.
- Push 20, push 13, MUL -> `result`=8'h04; push 8'hF0, AND -> `result`=8'h00, `depth`=1.
- With `depth`=1, send ADD -> `err`=1 for exactly one cycle with `err_code`=01; `depth` stays 1 and `result` is unchanged.
- Push 16 operands, then a 17th -> 17th gives `err_code`=10; `depth`=16 and `stk_full`=1; then ADD -> `depth`=15, `stk_full`=0.
- Hold `in_valid`=1 with tokens 1, 2, ADD, 4, ADD -> `in_ready` pattern 1,0,1,0,1,0,0,0,0,1,0,1,0,0,0,0,1; final `result`=7, `depth`=1.
- Assert `reset` during POP_B of an ADD -> next cycle `depth`=0, `in_ready`=1, `stk_push`=0, `stk_pop`=0, `stk_empty`=1; a following push of 9 gives `result`=9.
